// File: rtl/alu_pkg.sv
// Shared opcode, one-hot select and FSM state definitions for the ALU datapath
// and its command sequencer.
package alu_pkg;

   localparam int unsigned ALU_W = 16;
   localparam int unsigned SH_W  = 4;
   localparam int unsigned OP_W  = 4;
   localparam int unsigned SEL_W = 12;

   localparam logic [OP_W-1:0] OP_AND   = 4'd0;
   localparam logic [OP_W-1:0] OP_OR    = 4'd1;
   localparam logic [OP_W-1:0] OP_NOT   = 4'd2;
   localparam logic [OP_W-1:0] OP_XOR   = 4'd3;
   localparam logic [OP_W-1:0] OP_NAND  = 4'd4;
   localparam logic [OP_W-1:0] OP_NOR   = 4'd5;
   localparam logic [OP_W-1:0] OP_XNOR  = 4'd6;
   localparam logic [OP_W-1:0] OP_ADD   = 4'd7;
   localparam logic [OP_W-1:0] OP_SUB   = 4'd8;
   localparam logic [OP_W-1:0] OP_SHR   = 4'd9;
   localparam logic [OP_W-1:0] OP_SHL   = 4'd10;
   localparam logic [OP_W-1:0] OP_CLEAR = 4'd11;

   localparam logic [SEL_W-1:0] SEL_AND   = 12'h001;
   localparam logic [SEL_W-1:0] SEL_OR    = 12'h002;
   localparam logic [SEL_W-1:0] SEL_NOT   = 12'h004;
   localparam logic [SEL_W-1:0] SEL_XOR   = 12'h008;
   localparam logic [SEL_W-1:0] SEL_NAND  = 12'h010;
   localparam logic [SEL_W-1:0] SEL_NOR   = 12'h020;
   localparam logic [SEL_W-1:0] SEL_XNOR  = 12'h040;
   localparam logic [SEL_W-1:0] SEL_ADD   = 12'h080;
   localparam logic [SEL_W-1:0] SEL_SUB   = 12'h100;
   localparam logic [SEL_W-1:0] SEL_SHR   = 12'h200;
   localparam logic [SEL_W-1:0] SEL_SHL   = 12'h400;
   localparam logic [SEL_W-1:0] SEL_CLEAR = 12'h800;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SHIFT,
      ST_RESP
   } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-datapath and response signals between the sequencer and its
// environment; slave is the sequencer side.
interface alu_cmd_sequencer_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_W,
   parameter int unsigned SHW   = SH_W
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [OP_W-1:0]  cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_use_acc;
   logic [SHW-1:0]   cmd_shamt;
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_res;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;
   logic             rsp_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_shamt, alu_res, rsp_ready,
      output cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, rsp_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_shamt, alu_res, rsp_ready,
      input  cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 4-bit code to 12-bit one-hot ALU select,
// with codes outside the table flagged illegal and decoding to no select.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]  code_i,
   output logic [SEL_W-1:0] sel_c_o,
   output logic             illegal_c_o
);

   always_comb begin
      sel_c_o     = '0;
      illegal_c_o = 1'b0;
      case (code_i)
         OP_AND:   sel_c_o = SEL_AND;
         OP_OR:    sel_c_o = SEL_OR;
         OP_NOT:   sel_c_o = SEL_NOT;
         OP_XOR:   sel_c_o = SEL_XOR;
         OP_NAND:  sel_c_o = SEL_NAND;
         OP_NOR:   sel_c_o = SEL_NOR;
         OP_XNOR:  sel_c_o = SEL_XNOR;
         OP_ADD:   sel_c_o = SEL_ADD;
         OP_SUB:   sel_c_o = SEL_SUB;
         OP_SHR:   sel_c_o = SEL_SHR;
         OP_SHL:   sel_c_o = SEL_SHL;
         OP_CLEAR: sel_c_o = SEL_CLEAR;
         default:  illegal_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-level controller for the ALU datapath: accepts one op per handshake,
// drives the one-hot select, iterates 1-bit shifts and returns the accumulator.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_W,
   parameter int unsigned SHW   = SH_W
)(
   input  logic                clk,
   input  logic                rst,
   alu_cmd_sequencer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;

   logic [SEL_W-1:0] dec_sel_c;
   logic             dec_illegal_c;
   logic [WIDTH-1:0] a_in_c;
   logic             is_shift_c;

   alu_op_decode u_decode (
      .code_i      (bus.cmd_op),
      .sel_c_o     (dec_sel_c),
      .illegal_c_o (dec_illegal_c)
   );

   assign a_in_c     = bus.cmd_use_acc ? acc_q : bus.cmd_a;
   assign is_shift_c = (bus.cmd_op == OP_SHR) || (bus.cmd_op == OP_SHL);

   // Outputs are registered from the next state, so alu_sel is live during EXEC/SHIFT itself.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               rsp_err_d = 1'b0;
               alu_a_d   = a_in_c;
               alu_b_d   = bus.cmd_b;
               cnt_d     = bus.cmd_shamt;
               if (dec_illegal_c) begin
                  acc_d     = '0;
                  rsp_err_d = 1'b1;
                  state_d   = ST_RESP;
               end else if (is_shift_c && (bus.cmd_shamt == '0)) begin
                  acc_d   = a_in_c;
                  state_d = ST_RESP;
               end else if (is_shift_c) begin
                  sel_d   = dec_sel_c;
                  state_d = ST_SHIFT;
               end else begin
                  sel_d   = dec_sel_c;
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            acc_d   = bus.alu_res;
            sel_d   = '0;
            state_d = ST_RESP;
         end
         ST_SHIFT: begin
            alu_a_d = bus.alu_res;
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               acc_d   = bus.alu_res;
               sel_d   = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      rsp_zero_d  = (acc_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sel_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_zero_q  <= 1'b1;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.alu_sel   = sel_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = acc_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: emulated ALU mux, directed
// scenarios and randomized commands against an arithmetic reference model.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [15:0] m_acc = 16'h0000;

   alu_cmd_sequencer_if #(.WIDTH(16), .SHW(4)) bus ();

   alu_cmd_sequencer #(.WIDTH(16), .SHW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Combinational ALU mux; 0xDEAD flags a sample taken with no valid select
   always_comb begin
      case (bus.alu_sel)
         SEL_AND:   bus.alu_res = bus.alu_a & bus.alu_b;
         SEL_OR:    bus.alu_res = bus.alu_a | bus.alu_b;
         SEL_NOT:   bus.alu_res = ~bus.alu_a;
         SEL_XOR:   bus.alu_res = bus.alu_a ^ bus.alu_b;
         SEL_NAND:  bus.alu_res = ~(bus.alu_a & bus.alu_b);
         SEL_NOR:   bus.alu_res = ~(bus.alu_a | bus.alu_b);
         SEL_XNOR:  bus.alu_res = ~(bus.alu_a ^ bus.alu_b);
         SEL_ADD:   bus.alu_res = bus.alu_a + bus.alu_b;
         SEL_SUB:   bus.alu_res = bus.alu_a - bus.alu_b;
         SEL_SHR:   bus.alu_res = bus.alu_a >> 1;
         SEL_SHL:   bus.alu_res = bus.alu_a << 1;
         SEL_CLEAR: bus.alu_res = 16'h0000;
         default:   bus.alu_res = 16'hDEAD;
      endcase
   end

   // Reference: whole-command result from plain arithmetic
   function automatic void model(input int op, input logic [15:0] a, input logic [15:0] b,
                                 input int sh, output logic [15:0] res, output logic err);
      err = 1'b0;
      case (op)
         0:  res = a & b;
         1:  res = a | b;
         2:  res = ~a;
         3:  res = a ^ b;
         4:  res = ~(a & b);
         5:  res = ~(a | b);
         6:  res = ~(a ^ b);
         7:  res = a + b;
         8:  res = a - b;
         9:  res = a >> sh;
         10: res = a << sh;
         11: res = 16'h0000;
         default: begin res = 16'h0000; err = 1'b1; end
      endcase
   endfunction

   task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic use_acc, input logic [3:0] sh, input int hold,
                          input logic keep_valid, output int lat, output int sel_cycles,
                          output logic [11:0] sel_or, output logic [15:0] data,
                          output logic zero, output logic err, output logic stable);
      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = op;
      bus.cmd_a       = a;
      bus.cmd_b       = b;
      bus.cmd_use_acc = use_acc;
      bus.cmd_shamt   = sh;
      @(posedge clk);
      sel_cycles = 0;
      sel_or     = '0;
      stable     = 1'b1;
      @(negedge clk);
      if (!keep_valid) bus.cmd_valid = 1'b0;
      lat = 1;
      while (1) begin
         if (bus.alu_sel != '0) begin
            sel_cycles++;
            sel_or |= bus.alu_sel;
         end
         if (bus.rsp_valid || lat >= 40) break;
         @(negedge clk);
         lat++;
      end
      data = bus.rsp_data;
      zero = bus.rsp_zero;
      err  = bus.rsp_err;
      repeat (hold) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== data || bus.cmd_ready !== 1'b0 ||
             bus.alu_sel !== '0)
            stable = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
      bus.cmd_use_acc = 1'b0; bus.cmd_shamt = '0; bus.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_zero, bus.rsp_err} !== 4'b1010) begin
         n_errors++;
         $display("FAIL reset_flags: got rdy/vld/zero/err=%b required 1010",
                  {bus.cmd_ready, bus.rsp_valid, bus.rsp_zero, bus.rsp_err});
      end
      n_checks++;
      if (bus.alu_sel !== 12'h000 || bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 ||
          bus.rsp_data !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_bus: got sel=%h a=%h b=%h data=%h required all zero",
                  bus.alu_sel, bus.alu_a, bus.alu_b, bus.rsp_data);
      end
      m_acc = 16'h0000;
   endtask

   task automatic test_not();
      int lat, sc; logic [11:0] so; logic [15:0] d; logic z, e, st;
      run_cmd(4'd2, 16'h00F0, 16'h1234, 1'b0, 4'd0, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (sc != 1 || so !== 12'h004) begin
         n_errors++;
         $display("FAIL not_sel: got %0d cycles sel=%h required 1 cycle sel=004", sc, so);
      end
      n_checks++;
      if (lat != 2 || d !== 16'hFF0F || z !== 1'b0) begin
         n_errors++;
         $display("FAIL not_rsp: got lat=%0d data=%h zero=%b required lat=2 data=ff0f zero=0",
                  lat, d, z);
      end
      m_acc = 16'hFF0F;
   endtask

   task automatic test_add_sub();
      int lat, sc; logic [11:0] so; logic [15:0] d; logic z, e, st;
      run_cmd(4'd7, 16'hFFFF, 16'h0001, 1'b0, 4'd0, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (d !== 16'h0000 || z !== 1'b1 || lat != 2) begin
         n_errors++;
         $display("FAIL add_wrap: got data=%h zero=%b lat=%0d required 0000 1 2", d, z, lat);
      end
      run_cmd(4'd8, 16'h5555, 16'h0001, 1'b1, 4'd0, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (d !== 16'hFFFF || z !== 1'b0 || so !== 12'h100) begin
         n_errors++;
         $display("FAIL sub_acc: got data=%h zero=%b sel=%h required ffff 0 100", d, z, so);
      end
      m_acc = 16'hFFFF;
   endtask

   task automatic test_shift();
      int lat, sc; logic [11:0] so; logic [15:0] d; logic z, e, st;
      run_cmd(4'd10, 16'h0001, 16'h0000, 1'b0, 4'd4, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (sc != 4 || so !== 12'h400 || lat != 5) begin
         n_errors++;
         $display("FAIL shl_sel: got %0d cycles sel=%h lat=%0d required 4 400 5", sc, so, lat);
      end
      n_checks++;
      if (d !== 16'h0010) begin
         n_errors++;
         $display("FAIL shl_data: got %h required 0010", d);
      end
      run_cmd(4'd9, 16'h1234, 16'h0000, 1'b0, 4'd0, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (d !== 16'h1234 || sc != 0 || lat != 1) begin
         n_errors++;
         $display("FAIL shr_zero: got data=%h sel_cycles=%0d lat=%0d required 1234 0 1",
                  d, sc, lat);
      end
      m_acc = 16'h1234;
   endtask

   task automatic test_illegal();
      int lat, sc; logic [11:0] so; logic [15:0] d; logic z, e, st;
      run_cmd(4'd13, 16'hABCD, 16'h1111, 1'b0, 4'd3, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (e !== 1'b1 || d !== 16'h0000 || z !== 1'b1 || sc != 0 || lat != 1) begin
         n_errors++;
         $display("FAIL illegal: got err=%b data=%h zero=%b sel_cycles=%0d lat=%0d required 1 0000 1 0 1",
                  e, d, z, sc, lat);
      end
      run_cmd(4'd1, 16'h00A0, 16'h000B, 1'b0, 4'd0, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (e !== 1'b0 || d !== 16'h00AB) begin
         n_errors++;
         $display("FAIL err_clear: got err=%b data=%h required 0 00ab", e, d);
      end
      m_acc = 16'h00AB;
   endtask

   task automatic test_backpressure();
      int lat, sc; logic [11:0] so; logic [15:0] d; logic z, e, st;
      run_cmd(4'd7, 16'h1111, 16'h2222, 1'b0, 4'd0, 5, 1'b1, lat, sc, so, d, z, e, st);
      n_checks++;
      if (st !== 1'b1 || d !== 16'h3333) begin
         n_errors++;
         $display("FAIL backpressure_hold: got stable=%b data=%h required 1 3333", st, d);
      end
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.alu_sel !== 12'h000) begin
         n_errors++;
         $display("FAIL backpressure_no_second: got vld=%b rdy=%b sel=%h required 0 1 000",
                  bus.rsp_valid, bus.cmd_ready, bus.alu_sel);
      end
      m_acc = 16'h3333;
   endtask

   task automatic test_random();
      int lat, sc, op, sh, exp_lat, exp_sc, hold;
      logic [11:0] so, exp_so, one;
      logic [15:0] a, b, d, a_eff, exp_d;
      logic z, e, st, use_acc, exp_e;
      one = 12'h001;
      for (int i = 0; i < 40; i++) begin
         op      = $urandom_range(15, 0);
         sh      = $urandom_range(15, 0);
         a       = 16'($urandom);
         b       = 16'($urandom);
         use_acc = 1'($urandom);
         hold    = $urandom_range(2, 0);
         a_eff   = use_acc ? m_acc : a;
         model(op, a_eff, b, sh, exp_d, exp_e);
         if (op > 11)                            begin exp_lat = 1;      exp_sc = 0;  end
         else if ((op == 9 || op == 10) && sh == 0) begin exp_lat = 1;   exp_sc = 0;  end
         else if (op == 9 || op == 10)           begin exp_lat = sh + 1; exp_sc = sh; end
         else                                    begin exp_lat = 2;      exp_sc = 1;  end
         exp_so = (exp_sc > 0) ? (one << op) : 12'h000;
         run_cmd(4'(op), a, b, use_acc, 4'(sh), hold, 1'b0, lat, sc, so, d, z, e, st);
         n_checks++;
         if (d !== exp_d || e !== exp_e || z !== (exp_d == 16'h0)) begin
            n_errors++;
            $display("FAIL rand_rsp[%0d] op=%0d: got data=%h err=%b zero=%b required %h %b %b",
                     i, op, d, e, z, exp_d, exp_e, (exp_d == 16'h0));
         end
         n_checks++;
         if (lat != exp_lat || sc != exp_sc || so !== exp_so || st !== 1'b1) begin
            n_errors++;
            $display("FAIL rand_timing[%0d] op=%0d sh=%0d: got lat=%0d sel_cycles=%0d sel=%h stable=%b required %0d %0d %h 1",
                     i, op, sh, lat, sc, so, st, exp_lat, exp_sc, exp_so);
         end
         m_acc = exp_d;
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat, sc; logic [11:0] so; logic [15:0] d; logic z, e, st;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'd10; bus.cmd_a = 16'h0001;
      bus.cmd_b = 16'h0; bus.cmd_use_acc = 1'b0; bus.cmd_shamt = 4'd8;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.alu_sel !== 12'h400) begin
         n_errors++;
         $display("FAIL mid_shift_sel: got %h required 400", bus.alu_sel);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_sel !== 12'h000 ||
          bus.rsp_data !== 16'h0000 || bus.rsp_zero !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_shift_reset: got rdy=%b vld=%b sel=%h data=%h zero=%b required 1 0 000 0000 1",
                  bus.cmd_ready, bus.rsp_valid, bus.alu_sel, bus.rsp_data, bus.rsp_zero);
      end
      m_acc = 16'h0000;
      run_cmd(4'd7, 16'hFFFF, 16'h0005, 1'b1, 4'd0, 0, 1'b0, lat, sc, so, d, z, e, st);
      n_checks++;
      if (d !== 16'h0005) begin
         n_errors++;
         $display("FAIL post_reset_acc: got %h required 0005", d);
      end
      m_acc = 16'h0005;
   endtask

   initial begin
      test_reset();
      test_not();
      test_add_sub();
      test_shift();
      test_illegal();
      test_backpressure();
      test_random();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-level controller for the 16-bit ALU datapath. Accepts one operation per valid/ready handshake and drives the 12-bit one-hot operation select and operands into the ALU output mux. Captures the mux result into an accumulator and returns it on a valid/ready response channel. Multi-bit shifts are built by iterating the datapath's 1-bit shifters.

## Interface
Parameters:
- WIDTH, 16, datapath width (fixed at 16 for the current ALU)
- SHW, 4, shift-amount width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  encoded opcode (see Operation)
- cmd_a  in  16  operand A
- cmd_b  in  16  operand B
- cmd_use_acc  in  1  use accumulator instead of cmd_a as A
- cmd_shamt  in  SHW  shift count for SHR/SHL
- alu_sel  out  12  one-hot select to ALU mux
- alu_a  out  16  operand A to datapath
- alu_b  out  16  operand B to datapath
- alu_res  in  16  combinational mux result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  16  result (equals accumulator)
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  illegal opcode flag

## Operation
- Opcode codes 0–11 map to one-hot bit index n:
  - 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 ADD, 8 SUB, 9 SHR, 10 SHL, 11 CLEAR.
  - alu_sel = 1<<code.
- Codes 12–15 are illegal:
  - No EXEC cycle; alu_sel stays 0.
  - Accumulator cleared to 0; rsp_err=1.
- FSM states: IDLE, EXEC, SHIFT, RESP.
  - IDLE: cmd_ready=1, alu_sel=0. On cmd_valid, latch op/A/B/shamt. A = acc when cmd_use_acc, else cmd_a.
    - Illegal op → RESP.
    - SHR/SHL with shamt=0 → RESP with acc=A; no ALU cycle.
    - SHR/SHL with shamt>0 → SHIFT.
    - Anything else → EXEC.
  - EXEC: drive alu_sel/alu_a/alu_b; acc ← alu_res at the clock edge; → RESP.
  - SHIFT: drive the shift select with alu_a = working value.
    - Each cycle: working value ← alu_res and the remaining count is decremented.
    - When the count reaches 0, acc ← final value; → RESP.
  - RESP: rsp_valid=1, cmd_ready=0. On rsp_ready → IDLE.
- ADD/SUB: 16-bit wrap, carry discarded. 0xFFFF+0x0001 = 0x0000, rsp_zero=1.
- CLEAR: result is whatever the datapath returns for that select; acc takes alu_res.
- rsp_err is cleared on the next accepted command.
- cmd_ready is deasserted in every state except IDLE; cmd_valid there is ignored, not queued.

## Timing
- Reset values:
  - state=IDLE, acc=0, rsp_data=0, rsp_zero=1, rsp_err=0.
  - rsp_valid=0, cmd_ready=1, alu_sel=0, alu_a=0, alu_b=0.
- Latency from acceptance edge to rsp_valid:
  - 2 cycles for EXEC ops.
  - shamt+1 cycles for shifts with shamt>0.
  - 1 cycle for illegal ops and shamt=0 shifts.
- Throughput: minimum 3 cycles per EXEC command (accept, EXEC, RESP with rsp_ready=1).
- alu_res is sampled only in EXEC/SHIFT, in the same cycle alu_sel is driven. The datapath is purely combinational.
- rsp_valid holds, with stable rsp_data, until rsp_ready. Backpressure may be indefinite.
- rst asserted in any state, including mid-SHIFT or RESP: returns to IDLE and restores all reset values on the next edge. Any in-flight result is discarded.

## Structure
- Shared package alu_pkg holds:
  - 4-bit opcode constants OP_AND..OP_CLEAR (0–11).
  - 12-bit one-hot constants SEL_AND..SEL_CLEAR.
  - The FSM state enum.
  - The ALU mux uses the same constants.
- One sub-module, alu_op_decode: combinational 4-bit code → 12-bit one-hot plus illegal flag.
- The FSM, accumulator and shift counter live in the top.

## Test plan
- Reset, then NOT A=0x00F0 (code 2) → alu_sel=0x004 for one cycle; rsp_data=0xFF0F two cycles after acceptance; rsp_zero=0.
- ADD 0xFFFF,0x0001, then SUB with cmd_use_acc=1, B=0x0001 → first rsp_data=0x0000, rsp_zero=1; second 0xFFFF.
- SHL A=0x0001, shamt=4 → alu_sel=0x400 for exactly 4 cycles; rsp_data=0x0010. SHR shamt=0, A=0x1234 → 0x1234 with no alu_sel pulse.
- Illegal code 13 → rsp_err=1, rsp_data=0, alu_sel stays 0. The next valid command clears rsp_err.
- Hold rsp_ready=0 for 5 cycles while cmd_valid=1 → rsp_valid and rsp_data stable; cmd_ready=0; no second command accepted.
- rst asserted during cycle 2 of a shamt=8 shift → next cycle IDLE, acc=0, alu_sel=0, rsp_valid=0.
